axis_hsk_src: RTL and testbench

Source endpoint of a native 4-phase req/ack bus handshake, fed by an AXI-stream slave port in the s_axis_clk domain. Each accepted word is presented on hsk_data, and hsk_req is raised and held until the acknowledgement arrives from the peer destination endpoint in another clock domain. That destination endpoint is the block that converts the handshake back to AXI-stream. The block replaces the vendor handshake primitive on the source side of our clock-domain crossings. It adds a one-word skid entry, a stall timeout and a transfer counter.

---
 rtl/axis_hsk_src.sv | 145 ++++++++++++++
 tb/tb_axis_hsk_src.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_hsk_src.sv
// axis_hsk_src: source end of a 4-phase req/ack handshake fed from an
// AXI-stream slave port. One word is held on hsk_data while hsk_req is up;
// a single skid entry absorbs a frame that arrives while the hold register
// is busy. A stall timeout drops the block into a terminal error state, and
// a free-running counter tallies completed transfers.
module axis_hsk_src #(
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_FF        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   s_axis_clk,
  input  logic                   rst,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  output logic                   hsk_req,
  input  logic                   hsk_ack,
  output logic [DATA_WIDTH-1:0]  hsk_data,
  output logic                   timeout,
  output logic [COUNT_WIDTH-1:0] xfer_count
);

  // The stall counter only has to reach TIMEOUT_CYCLES-1 before firing.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    REQ   = 3'd2,
    DROP  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t                  state;
  logic [SYNC_FF-1:0]      ack_ff;
  logic                    ack_sync;
  logic                    skid_valid;
  logic [DATA_WIDTH-1:0]   skid_data;
  logic [TW-1:0]           tcnt;
  logic                    accept;
  logic                    busy_accept;

  // Ready depends only on registered state (plus reset), so it never
  // combinationally follows tvalid.
  assign s_axis_tready = ~rst & ~skid_valid & (state != ERR);
  assign accept        = s_axis_tvalid & s_axis_tready;
  // A frame taken while the hold register is busy goes to the skid entry.
  assign busy_accept   = accept & (state != IDLE);
  assign ack_sync      = ack_ff[SYNC_FF-1];

  // Bring the peer's asynchronous acknowledge into this clock domain.
  always_ff @(posedge s_axis_clk) begin
    if (rst) begin
      ack_ff <= '0;
    end else begin
      ack_ff <= {ack_ff[SYNC_FF-2:0], hsk_ack};
    end
  end

  // Capture the skid word; its contents are meaningless until skid_valid.
  always_ff @(posedge s_axis_clk) begin
    if (busy_accept) begin
      skid_data <= s_axis_tdata;
    end
  end

  // Handshake sequencer with registered req/data, stall timer and counter.
  always_ff @(posedge s_axis_clk) begin
    if (rst) begin
      state      <= IDLE;
      hsk_req    <= 1'b0;
      hsk_data   <= '0;
      timeout    <= 1'b0;
      xfer_count <= '0;
      skid_valid <= 1'b0;
      tcnt       <= '0;
    end else begin
      if (busy_accept) begin
        skid_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          tcnt <= '0;
          // A parked skid word always goes before anything new.
          if (skid_valid) begin
            hsk_data   <= skid_data;
            skid_valid <= 1'b0;
            state      <= SETUP;
          end else if (accept) begin
            hsk_data <= s_axis_tdata;
            state    <= SETUP;
          end
        end
        SETUP: begin
          // Data has been stable for a full cycle; now raise the request.
          hsk_req <= 1'b1;
          tcnt    <= '0;
          state   <= REQ;
        end
        REQ: begin
          // An acknowledge wins over a timeout expiring in the same cycle.
          if (ack_sync) begin
            hsk_req    <= 1'b0;
            xfer_count <= xfer_count + 1'b1;
            tcnt       <= '0;
            state      <= DROP;
          end else if (TO_EN && (tcnt == TLAST)) begin
            hsk_req <= 1'b0;
            timeout <= 1'b1;
            tcnt    <= '0;
            state   <= ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DROP: begin
          if (!ack_sync) begin
            tcnt  <= '0;
            state <= IDLE;
          end else if (TO_EN && (tcnt == TLAST)) begin
            timeout <= 1'b1;
            tcnt    <= '0;
            state   <= ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ERR: begin
          // Terminal: both handshake ends need a reset to recover.
          hsk_req <= 1'b0;
          tcnt    <= '0;
        end
        default: begin
          hsk_req <= 1'b0;
          tcnt    <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_hsk_src.sv
// Directed bench for axis_hsk_src: three instances (default parameters,
// short timeout, narrow counter with deeper synchronizer) share clock and
// reset. Accepted words are queued per instance and checked when the DUT
// raises hsk_req.
module tb_axis_hsk_src;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // instance A: defaults, ack either looped back or driven manually
  logic        tvalid_a = 1'b0, tready_a, req_a, ack_a, timeout_a;
  logic [31:0] tdata_a = '0, data_a;
  logic [15:0] count_a;
  logic        loop_a = 1'b1, man_a = 1'b0;
  assign ack_a = loop_a ? req_a : man_a;

  // instance T: TIMEOUT_CYCLES=16, ack stuck low
  logic        tvalid_t = 1'b0, tready_t, req_t, timeout_t;
  logic        ack_t = 1'b0;
  logic [31:0] tdata_t = '0, data_t;
  logic [15:0] count_t;

  // instance W: SYNC_FF=3, COUNT_WIDTH=4, loopback ack
  logic        tvalid_w = 1'b0, tready_w, req_w, ack_w, timeout_w;
  logic [31:0] tdata_w = '0, data_w;
  logic [3:0]  count_w;
  assign ack_w = req_w;

  axis_hsk_src dut_a (
    .s_axis_clk(clk), .rst(rst), .s_axis_tvalid(tvalid_a), .s_axis_tready(tready_a),
    .s_axis_tdata(tdata_a), .hsk_req(req_a), .hsk_ack(ack_a), .hsk_data(data_a),
    .timeout(timeout_a), .xfer_count(count_a)
  );

  axis_hsk_src #(.TIMEOUT_CYCLES(16)) dut_t (
    .s_axis_clk(clk), .rst(rst), .s_axis_tvalid(tvalid_t), .s_axis_tready(tready_t),
    .s_axis_tdata(tdata_t), .hsk_req(req_t), .hsk_ack(ack_t), .hsk_data(data_t),
    .timeout(timeout_t), .xfer_count(count_t)
  );

  axis_hsk_src #(.SYNC_FF(3), .COUNT_WIDTH(4)) dut_w (
    .s_axis_clk(clk), .rst(rst), .s_axis_tvalid(tvalid_w), .s_axis_tready(tready_w),
    .s_axis_tdata(tdata_w), .hsk_req(req_w), .hsk_ack(ack_w), .hsk_data(data_w),
    .timeout(timeout_w), .xfer_count(count_w)
  );

  logic [31:0] q_a[$];
  logic [31:0] q_w[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    assert (got === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word to instance sel (0=A, 1=T, 2=W) and wait for the edge
  // that accepts it; tvalid is left high so back-to-back sends stream.
  int acc_cyc = 0;
  task automatic send(input int sel, input logic [31:0] d);
    int  n;
    bit  ok;
    logic rdy;
    n  = 0;
    ok = 1'b0;
    if (sel == 0) begin tvalid_a = 1'b1; tdata_a = d; end
    else if (sel == 1) begin tvalid_t = 1'b1; tdata_t = d; end
    else begin tvalid_w = 1'b1; tdata_w = d; end
    while (!ok && n < 300) begin
      rdy = (sel == 0) ? tready_a : (sel == 1) ? tready_t : tready_w;
      tick();
      n++;
      if (rdy) ok = 1'b1;
    end
    chk("send_accept", 64'(ok), 64'd1);
    if (ok) begin
      acc_cyc = cyc;
      if (sel == 0) q_a.push_back(d);
      else if (sel == 2) q_w.push_back(d);
    end
  endtask

  task automatic wait_cnt_a(input logic [15:0] target, input int max);
    int n;
    n = 0;
    while (count_a !== target && n < max) begin
      tick();
      n++;
    end
    chk("wait_cnt_a", 64'(count_a), 64'(target));
  endtask

  // Scoreboard and data-stability monitor for instance A.
  logic        req_a_q = 1'b0;
  logic [31:0] data_a_q = '0;
  always @(negedge clk) begin
    logic [31:0] exp;
    if (req_a && !req_a_q) begin
      exp = 'x;
      if (q_a.size() > 0) exp = q_a.pop_front();
      chk("a_word", 64'(data_a), 64'(exp));
    end else if (req_a && req_a_q) begin
      chk("a_stable", 64'(data_a), 64'(data_a_q));
    end
    req_a_q  <= req_a;
    data_a_q <= data_a;
  end

  // Scoreboard and period monitor for instance W.
  logic req_w_q = 1'b0;
  int   n_rise_w = 0;
  int   last_rise_w = 0;
  always @(negedge clk) begin
    logic [31:0] exp;
    if (req_w && !req_w_q) begin
      exp = 'x;
      if (q_w.size() > 0) exp = q_w.pop_front();
      chk("w_word", 64'(data_w), 64'(exp));
      if (n_rise_w > 0) chk("w_period", 64'(cyc - last_rise_w), 64'd10);
      last_rise_w <= cyc;
      n_rise_w    <= n_rise_w + 1;
    end
    req_w_q <= req_w;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c1, c2, c3, n;
    bit held;

    // reset values
    repeat (3) tick();
    chk("rst_tready_a", 64'(tready_a), 64'd0);
    chk("rst_req_a", 64'(req_a), 64'd0);
    chk("rst_data_a", 64'(data_a), 64'd0);
    chk("rst_timeout_a", 64'(timeout_a), 64'd0);
    chk("rst_count_a", 64'(count_a), 64'd0);
    chk("rst_req_w", 64'(req_w), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_tready_a", 64'(tready_a), 64'd1);

    // single word with loopback, then a second word parked in skid
    send(0, 32'hDEADBEEF);
    tvalid_a = 1'b0;
    chk("t1_data_e0", 64'(data_a), 64'hDEADBEEF);
    chk("t1_req_e0", 64'(req_a), 64'd0);
    tick();
    chk("t1_req_e1", 64'(req_a), 64'd1);
    tick(); tick();
    chk("t1_req_e3", 64'(req_a), 64'd1);
    chk("t1_cnt_e3", 64'(count_a), 64'd0);
    tick();
    chk("t1_req_e4", 64'(req_a), 64'd0);
    chk("t1_cnt_e4", 64'(count_a), 64'd1);
    send(0, 32'hCAFEF00D);
    tvalid_a = 1'b0;
    chk("t1_skid_tready", 64'(tready_a), 64'd0);
    tick(); tick();
    chk("t1_hold_e7", 64'(data_a), 64'hDEADBEEF);
    tick();
    chk("t1_reload_e8", 64'(data_a), 64'hCAFEF00D);
    chk("t1_tready_e8", 64'(tready_a), 64'd1);
    wait_cnt_a(16'd2, 40);
    repeat (10) tick();

    // burst of three with tvalid held
    send(0, 32'h1);
    c1 = acc_cyc;
    send(0, 32'h2);
    c2 = acc_cyc;
    chk("burst_b2b", 64'(c2 - c1), 64'd1);
    chk("burst_tready_low", 64'(tready_a), 64'd0);
    send(0, 32'h3);
    c3 = acc_cyc;
    tvalid_a = 1'b0;
    chk("burst_third_gap", 64'(c3 - c2), 64'd8);
    wait_cnt_a(16'd5, 60);
    repeat (10) tick();

    // delayed acknowledge, 50 cycles after req rises
    loop_a = 1'b0;
    man_a  = 1'b0;
    send(0, 32'hA5A50001);
    tvalid_a = 1'b0;
    tick();
    held = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (req_a !== 1'b1) held = 1'b0;
      tick();
    end
    chk("dly_req_held", 64'(held), 64'd1);
    man_a = 1'b1;
    n = 0;
    while (req_a !== 1'b0 && n < 10) begin tick(); n++; end
    chk("dly_req_fall", 64'(req_a), 64'd0);
    chk("dly_timeout", 64'(timeout_a), 64'd0);
    chk("dly_count", 64'(count_a), 64'd6);
    man_a = 1'b0;
    repeat (8) tick();

    // acknowledge already high when REQ is entered
    man_a = 1'b1;
    repeat (4) tick();
    send(0, 32'h5A5A0002);
    tvalid_a = 1'b0;
    chk("early_req_setup", 64'(req_a), 64'd0);
    tick();
    chk("early_req_up", 64'(req_a), 64'd1);
    tick();
    chk("early_req_down", 64'(req_a), 64'd0);
    chk("early_count", 64'(count_a), 64'd7);
    man_a = 1'b0;
    repeat (8) tick();
    chk("early_tready", 64'(tready_a), 64'd1);

    // reset while in REQ with the skid full
    send(0, 32'h111);
    send(0, 32'h222);
    tvalid_a = 1'b0;
    chk("mid_skid_full", 64'(tready_a), 64'd0);
    chk("mid_req_up", 64'(req_a), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_req", 64'(req_a), 64'd0);
    chk("mid_rst_tready", 64'(tready_a), 64'd0);
    chk("mid_rst_data", 64'(data_a), 64'd0);
    chk("mid_rst_count", 64'(count_a), 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_post_tready", 64'(tready_a), 64'd1);
    q_a.delete();
    loop_a = 1'b1;
    send(0, 32'h333);
    tvalid_a = 1'b0;
    wait_cnt_a(16'd1, 20);
    repeat (20) tick();
    chk("mid_skid_gone", 64'(count_a), 64'd1);
    chk("a_no_timeout", 64'(timeout_a), 64'd0);

    // stuck acknowledge with a 16-cycle timeout
    send(1, 32'h77);
    tvalid_t = 1'b0;
    tick();
    chk("to_req_up", 64'(req_t), 64'd1);
    repeat (15) tick();
    chk("to_not_yet", 64'(timeout_t), 64'd0);
    chk("to_req_still", 64'(req_t), 64'd1);
    tick();
    chk("to_flag", 64'(timeout_t), 64'd1);
    chk("to_req_drop", 64'(req_t), 64'd0);
    chk("to_tready", 64'(tready_t), 64'd0);
    chk("to_count", 64'(count_t), 64'd0);
    tvalid_t = 1'b1;
    repeat (5) tick();
    chk("to_err_tready", 64'(tready_t), 64'd0);
    chk("to_err_sticky", 64'(timeout_t), 64'd1);
    chk("to_err_req", 64'(req_t), 64'd0);
    tvalid_t = 1'b0;
    rst = 1'b1;
    tick();
    chk("to_rst_flag", 64'(timeout_t), 64'd0);
    chk("to_rst_data", 64'(data_t), 64'd0);
    chk("to_rst_count", 64'(count_t), 64'd0);
    rst = 1'b0;
    #1;
    chk("to_rst_tready", 64'(tready_t), 64'd1);

    // 17 streamed transfers into a 4-bit counter
    for (int i = 0; i < 17; i++) send(2, 32'h100 + i);
    tvalid_w = 1'b0;
    n = 0;
    while (!(n_rise_w == 17 && req_w == 1'b0) && n < 400) begin tick(); n++; end
    chk("wrap_rises", 64'(n_rise_w), 64'd17);
    chk("wrap_count", 64'(count_w), 64'd1);
    chk("wrap_timeout", 64'(timeout_w), 64'd0);

    repeat (10) tick();
    chk("a_queue_empty", 64'(q_a.size()), 64'd0);
    chk("w_queue_empty", 64'(q_w.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
